// File: rtl/life_sequencer.sv
// Generation sequencer for a Game-of-Life frame engine: paces INIT/UPDATE/COPY
// phases against vsync. Optional per-phase watchdog enabled by LIFE_SEQ_WATCHDOG_EN.
module life_sequencer #(
  parameter int WDOG_CYCLES = 65535,
  parameter int GEN_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             vsync,
  input  logic             run,
  input  logic             step,
  input  logic             randomize,
  input  logic [2:0]       rate,
  output logic             init_start,
  output logic             update_start,
  output logic             copy_start,
  input  logic             init_done,
  input  logic             update_done,
  input  logic             copy_done,
  output logic [1:0]       phase,
  output logic             busy,
  output logic [GEN_W-1:0] gen_count,
  output logic             wdog_err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    INIT   = 2'd1,
    UPDATE = 2'd2,
    COPY   = 2'd3
  } state_e;

  state_e     state, state_next;
  logic       vsync_q;
  logic       tick;
  logic       boot_pend;
  logic       step_pend;
  logic [2:0] frame_cnt;
  logic       launch;
  logic       timeout;

  // The counter must be able to hold WDOG_CYCLES-1, so at least one bit.
  if (WDOG_CYCLES < 2) begin : g_wdog_range
    $error("life_sequencer: WDOG_CYCLES must be at least 2");
  end

  assign tick  = vsync & ~vsync_q;
  assign phase = state;
  assign busy  = (state != IDLE);

  // NOTE: every signal written here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_next = state;
    launch     = 1'b0;
    case (state)
      IDLE: begin
        if (boot_pend) begin
          state_next = INIT;
        end else if (tick && (run ? (frame_cnt >= rate) : step_pend)) begin
          launch     = 1'b1;
          state_next = randomize ? INIT : UPDATE;
        end
      end
      INIT:    if (init_done)   state_next = IDLE;
      UPDATE:  if (update_done) state_next = COPY;
      COPY:    if (copy_done)   state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (timeout) state_next = IDLE;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of the others, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      vsync_q      <= 1'b1;
      boot_pend    <= 1'b1;
      step_pend    <= 1'b0;
      frame_cnt    <= '0;
      gen_count    <= '0;
      init_start   <= 1'b0;
      update_start <= 1'b0;
      copy_start   <= 1'b0;
    end else begin
      state        <= state_next;
      vsync_q      <= vsync;
      // Reset always lands in IDLE, so the forced boot launch happens on this first edge.
      boot_pend    <= 1'b0;
      init_start   <= (state_next == INIT)   && (state != INIT);
      update_start <= (state_next == UPDATE) && (state != UPDATE);
      copy_start   <= (state_next == COPY)   && (state != COPY);

      if (run || launch) begin
        step_pend <= 1'b0;
      end else if (step && (state == IDLE)) begin
        step_pend <= 1'b1;
      end

      if ((state == IDLE) && tick) begin
        frame_cnt <= launch ? 3'd0 : frame_cnt + 3'd1;
      end

      if ((state == COPY) && copy_done) begin
        gen_count <= gen_count + 1'b1;
      end else if ((state == INIT) && init_done) begin
        gen_count <= '0;
      end
    end
  end

`ifdef LIFE_SEQ_WATCHDOG_EN
  localparam int WDOG_W = $clog2(WDOG_CYCLES);

  logic [WDOG_W-1:0] wdog_cnt;
  logic              phase_done;
  logic              wdog_q;

  always_comb begin
    phase_done = 1'b0;
    case (state)
      INIT:    phase_done = init_done;
      UPDATE:  phase_done = update_done;
      COPY:    phase_done = copy_done;
      default: phase_done = 1'b0;
    endcase
  end

  // A done arriving on the last allowed cycle still wins over the timeout.
  assign timeout = (state != IDLE) && !phase_done &&
                   (wdog_cnt == WDOG_W'(WDOG_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdog_cnt <= '0;
      wdog_q   <= 1'b0;
    end else begin
      if (state_next != state) begin
        wdog_cnt <= '0;
      end else if (state != IDLE) begin
        wdog_cnt <= wdog_cnt + 1'b1;
      end
      if (timeout) wdog_q <= 1'b1;
    end
  end

  assign wdog_err = wdog_q;
`else
  assign timeout  = 1'b0;
  assign wdog_err = 1'b0;
`endif

endmodule

// File: tb/tb_life_sequencer.sv
// Scoreboard bench for life_sequencer: expected start pulses are queued by the
// stimulus and checked by an independent monitor against a bench engine model.
module tb_life_sequencer;

  localparam int DONE_LAT  = 10;
  localparam int FRAME_LEN = 30;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        vsync = 1'b0;
  logic        run = 1'b0;
  logic        step = 1'b0;
  logic        randomize = 1'b0;
  logic [2:0]  rate = 3'd0;
  logic        init_start, update_start, copy_start;
  logic        init_done, update_done, copy_done;
  logic [1:0]  phase;
  logic        busy;
  logic [15:0] gen_count;
  logic        wdog_err;

  logic eng_init_done = 1'b0, eng_update_done = 1'b0, eng_copy_done = 1'b0;
  logic stray_update_done = 1'b0, stray_copy_done = 1'b0;
  bit   withhold_update = 1'b0;
  logic upd_done_prev = 1'b0;

  assign init_done   = eng_init_done;
  assign update_done = eng_update_done | stray_update_done;
  assign copy_done   = eng_copy_done | stray_copy_done;

  life_sequencer #(.WDOG_CYCLES(8), .GEN_W(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .vsync        (vsync),
    .run          (run),
    .step         (step),
    .randomize    (randomize),
    .rate         (rate),
    .init_start   (init_start),
    .update_start (update_start),
    .copy_start   (copy_start),
    .init_done    (init_done),
    .update_done  (update_done),
    .copy_done    (copy_done),
    .phase        (phase),
    .busy         (busy),
    .gen_count    (gen_count),
    .wdog_err     (wdog_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int tick_count = 0;

  typedef struct {
    int kind;
    int tick;
    int gen;
  } exp_t;

  exp_t exp_q[$];

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic expect_start(input int kind, input int tick, input int gen);
    exp_t e;
    e.kind = kind;
    e.tick = tick;
    e.gen  = gen;
    exp_q.push_back(e);
  endtask

  // One vsync frame; optional step pulse on the rising edge or mid-frame.
  task automatic frame(input bit step_at_tick, input bit step_mid);
    for (int i = 0; i < FRAME_LEN; i++) begin
      @(negedge clk);
      vsync = (i < 2);
      if (i == 0) tick_count++;
      step = (step_at_tick && i == 0) || (step_mid && i == 5);
    end
    step = 1'b0;
  endtask

  task automatic step_pulse();
    @(negedge clk);
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (phase !== 2'd0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (phase !== 2'd0) check("wait_idle_timeout", phase, 0);
  endtask

  // Engine model: each engine answers its start with a done DONE_LAT cycles later.
  initial begin
    int init_rem = 0, upd_rem = 0, copy_rem = 0;
    forever begin
      @(negedge clk);
      eng_init_done   = 1'b0;
      eng_update_done = 1'b0;
      eng_copy_done   = 1'b0;
      if (init_rem > 0) begin init_rem--; if (init_rem == 0) eng_init_done = 1'b1; end
      if (upd_rem > 0)  begin upd_rem--;  if (upd_rem == 0)  eng_update_done = 1'b1; end
      if (copy_rem > 0) begin copy_rem--; if (copy_rem == 0) eng_copy_done = 1'b1; end
      if (init_start) init_rem = DONE_LAT;
      if (update_start && !withhold_update) upd_rem = DONE_LAT;
      if (copy_start) copy_rem = DONE_LAT;
    end
  end

  initial forever begin
    @(posedge clk);
    upd_done_prev = update_done;
  end

  // Monitor: every start pulse must match the head of the expectation queue.
  initial forever begin
    @(negedge clk);
    if (rst_n && (init_start || update_start || copy_start)) begin
      int   obs;
      exp_t e;
      obs = init_start ? 1 : (update_start ? 2 : 3);
      check("start_onehot", $countones({init_start, update_start, copy_start}), 1);
      if (copy_start) check("copy_after_update_done", upd_done_prev, 1);
      if (exp_q.size() == 0) begin
        check("unexpected_start", obs, 0);
      end else begin
        e = exp_q.pop_front();
        check("start_kind", obs, e.kind);
        check("start_tick", tick_count, e.tick);
        check("start_gen", gen_count, e.gen);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_phase", phase, 0);
    check("rst_starts", {init_start, update_start, copy_start}, 0);
    check("rst_busy", busy, 0);
    check("rst_gen", gen_count, 0);
    check("rst_wdog", wdog_err, 0);

    // Boot: INIT forced on the first clock without any vsync edge.
    expect_start(1, 0, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("boot_phase", phase, 1);
    check("boot_busy", busy, 1);
    wait_idle(40);
    check("boot_gen", gen_count, 0);

    // Free-run with rate=2: a generation every third tick.
    run = 1'b1;
    rate = 3'd2;
    expect_start(2, 3, 0); expect_start(3, 3, 0);
    expect_start(2, 6, 1); expect_start(3, 6, 1);
    expect_start(2, 9, 2); expect_start(3, 9, 2);
    repeat (9) frame(1'b0, 1'b0);
    run = 1'b0;
    check("run_gen", gen_count, 3);

    // Single step; a second step during the busy pair is ignored.
    step_pulse();
    expect_start(2, 10, 3); expect_start(3, 10, 3);
    frame(1'b0, 1'b1);
    frame(1'b0, 1'b0);
    check("step_gen", gen_count, 4);

    // Step coincident with a tick is served at the following tick.
    expect_start(2, 13, 4); expect_start(3, 13, 4);
    frame(1'b1, 1'b0);
    frame(1'b0, 1'b0);
    check("step_tick_gen", gen_count, 5);

    // Randomize at trigger selects INIT and clears the generation count.
    run = 1'b1;
    rate = 3'd0;
    randomize = 1'b1;
    expect_start(1, 14, 5);
    frame(1'b0, 1'b0);
    run = 1'b0;
    randomize = 1'b0;
    check("rand_gen", gen_count, 0);

    // Stray done pulses in IDLE have no effect.
    @(negedge clk); stray_copy_done = 1'b1;
    @(negedge clk); stray_copy_done = 1'b0; stray_update_done = 1'b1;
    @(negedge clk); stray_update_done = 1'b0;
    repeat (3) @(negedge clk);
    check("stray_gen", gen_count, 0);
    check("stray_phase", phase, 0);
    check("pre_wdog_err", wdog_err, 0);

    // Withheld update_done: watchdog (if built) returns to IDLE after 8 cycles.
    withhold_update = 1'b1;
    step_pulse();
    expect_start(2, 15, 0);
    @(negedge clk);
    vsync = 1'b1;
    tick_count++;
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk);
      if (i == 2) vsync = 1'b0;
      if (i == 8) check("wdog_phase_before", phase, 2);
    end
`ifdef LIFE_SEQ_WATCHDOG_EN
    check("wdog_phase_after", phase, 0);
    check("wdog_err_set", wdog_err, 1);
`else
    check("nowdog_phase_after", phase, 2);
    check("nowdog_err", wdog_err, 0);
`endif
    check("wdog_gen", gen_count, 0);

    repeat (5) @(negedge clk);
    check("exp_queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/life_sequencer.md
LIFE_SEQUENCER -- requirements
Module: life_sequencer

Interface
REQ-001: Parameter WDOG_CYCLES, default 65535, sets the watchdog limit in clk cycles per phase (used only when LIFE_SEQ_WATCHDOG_EN is defined).
REQ-002: Parameter GEN_W, default 16, sets the width of the generation counter.
REQ-003: Port clk, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-004: Port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-005: Port vsync, input, 1 bit, frame sync level in the clk domain; a frame tick is its 0->1 edge, detected against a registered copy.
REQ-006: Port run, input, 1 bit, level; 1 = free-running generations.
REQ-007: Port step, input, 1 bit, single-generation request pulse; honoured only while run=0.
REQ-008: Port randomize, input, 1 bit, level; sampled at trigger and selects INIT instead of UPDATE.
REQ-009: Port rate, input, 3 bits, frames per generation minus one.
REQ-010: Ports init_start, update_start and copy_start, outputs, 1 bit each, one-cycle start pulses to the init, update and copy engines.
REQ-011: Ports init_done, update_done and copy_done, inputs, 1 bit each, one-cycle completion pulses from the engines.
REQ-012: Port phase, output, 2 bits, current state encoded as IDLE=0, INIT=1, UPDATE=2, COPY=3.
REQ-013: Port busy, output, 1 bit, 1 whenever phase!=IDLE.
REQ-014: Port gen_count, output, GEN_W bits, number of generations completed.
REQ-015: Port wdog_err, output, 1 bit, sticky watchdog error flag.

Function
REQ-016: The state machine SHALL have states IDLE, INIT, UPDATE and COPY and no others; any unreachable encoding SHALL return to IDLE on the next cycle.
REQ-017: On entry to INIT, UPDATE or COPY, the matching *_start output SHALL pulse high for exactly the entry cycle, registered, with 1-cycle latency from the transition decision.
REQ-018: INIT->IDLE on init_done; UPDATE->COPY on update_done; COPY->IDLE on copy_done; each *_done SHALL be honoured only in its own state and ignored in all other states.
REQ-019: In IDLE, on each frame tick the frame counter SHALL increment; when run=1, a frame tick occurs and frame_cnt>=rate, the block SHALL clear frame_cnt and go to INIT if randomize=1, else to UPDATE.
REQ-020: Frame ticks occurring outside IDLE SHALL NOT increment frame_cnt.
REQ-021: A step pulse with run=0 SHALL set step_pend; at the next frame tick in IDLE, step_pend SHALL clear and one generation SHALL launch regardless of rate.
REQ-022: A step pulse arriving with run=1, or while step_pend=1, SHALL be ignored.
REQ-023: A step pulse arriving in the same cycle as a frame tick SHALL be latched and served at the following tick.
REQ-024: step_pend SHALL clear if run goes to 1.
REQ-025: gen_count SHALL increment by 1 on an accepted copy_done, wrap from all-ones to 0, and clear to 0 on an accepted init_done.
REQ-026: Changing rate mid-count SHALL take effect at the next tick through the >= compare.
REQ-027: A boot_pend flag, set by reset, SHALL force IDLE->INIT on the first clock after reset release without waiting for vsync, and SHALL clear on that transition.

Reset
REQ-028: While rst_n=0, asynchronously: phase=IDLE, all *_start=0, busy=0, gen_count=0, wdog_err=0, frame_cnt=0, step_pend=0, boot_pend=1, vsync history register=1.
REQ-029: Reset asserted mid-phase SHALL abandon that phase with no start pulse and no count change.

Configuration
REQ-030: With macro LIFE_SEQ_WATCHDOG_EN defined, a per-phase cycle counter SHALL run in INIT, UPDATE and COPY; if it reaches WDOG_CYCLES without the matching done, the block SHALL go to IDLE, set wdog_err=1 (sticky until reset) and leave gen_count unchanged.
REQ-031: Without LIFE_SEQ_WATCHDOG_EN, no watchdog counter SHALL be built, wdog_err SHALL be tied to 0, and phases SHALL wait indefinitely for their done.

Verification
REQ-032: Release reset with vsync=0 -> init_start pulses on the 2nd clock, phase=1; init_done -> phase=0 and gen_count=0.
REQ-033: run=1, rate=2, engine model returning done 10 cycles after start -> update_start on every 3rd vsync edge, copy_start 1 cycle after update_done, gen_count=1,2,3.
REQ-034: run=0, single step pulse, then 2 vsync edges -> exactly one UPDATE/COPY pair, gen_count+1; a second step given during that pair -> no extra generation.
REQ-035: run=1, randomize=1 at trigger -> init_start (not update_start) and gen_count returns to 0; a stray copy_done injected in IDLE -> no change.
REQ-036: With LIFE_SEQ_WATCHDOG_EN and WDOG_CYCLES=8, update_done withheld -> phase=0 and wdog_err=1 after 8 cycles; without the macro -> phase stays 2.
